// File: rtl/mu0_mux_pkg.sv
// mu0_mux_pkg: shared arbitration types and the one-hot grant search function
package mu0_mux_pkg;

    typedef enum logic {MODE_FIXED, MODE_RR} arb_mode_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    // upper bound on channel count the shared grant function handles
    localparam int MAX_N = 32;

    // first requester at or after start, wrapping at n; zero if none request
    function automatic logic [MAX_N-1:0] rr_grant(input logic [MAX_N-1:0] req, input int n, input int start);
        logic [MAX_N-1:0] g;
        logic found;
        int idx;
        g = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                idx = start + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    g[idx] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mu0_rr_arbiter.sv
// mu0_rr_arbiter: fixed-priority or round-robin grant with its own rotating pointer
module mu0_rr_arbiter
    import mu0_mux_pkg::*;
#(
    parameter int        N    = 4,
    parameter arb_mode_t MODE = MODE_RR,
    localparam int       CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic [N-1:0]  Req,
    input  logic          Advance,
    output logic [N-1:0]  Grant,
    output logic [CW-1:0] Grant_Idx
);

    logic [CW-1:0]    ptr;
    logic [MAX_N-1:0] g_all;

    // search from the pointer (or from 0 in fixed mode) and encode the winner
    always_comb begin
        g_all = rr_grant(MAX_N'(Req), N, (MODE == MODE_RR) ? int'(ptr) : 0);
        Grant = g_all[N-1:0];
        Grant_Idx = '0;
        for (int i = 0; i < MAX_N; i++)
            if (g_all[i]) Grant_Idx = CW'(i);
    end

    // move the pointer just past the channel that transferred
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) ptr <= '0;
        else if (Advance && MODE == MODE_RR) ptr <= (int'(Grant_Idx) == N - 1) ? '0 : Grant_Idx + 1'b1;
    end

endmodule

// File: rtl/mu0_arb_mux.sv
// mu0_arb_mux: arbitrated N-channel valid/ready mux with a registered output stage
module mu0_arb_mux
    import mu0_mux_pkg::*;
#(
    parameter int        WIDTH = 12,
    parameter int        N     = 4,
    parameter arb_mode_t MODE  = MODE_RR,
    localparam int       CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic [N*WIDTH-1:0]   In_Data,
    input  logic [N-1:0]         In_Valid,
    output logic [N-1:0]         In_Ready,
    output logic [WIDTH-1:0]     Out_Data,
    output logic [CW-1:0]        Out_Chan,
    output logic                 Out_Valid,
    input  logic                 Out_Ready
);

    out_state_t    state;
    logic          accept;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [CW-1:0] grant_idx;

    // the output slot can take a word when empty or being drained this cycle;
    // holding reset kills requests so nothing is offered while flops are cleared
    assign accept   = (state == EMPTY) | Out_Ready;
    assign req      = In_Valid & {N{accept & nReset}};
    assign In_Ready = grant;
    assign Out_Valid = (state == FULL);

    mu0_rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .Clk       (Clk),
        .nReset    (nReset),
        .Req       (req),
        .Advance   (|grant),
        .Grant     (grant),
        .Grant_Idx (grant_idx)
    );

    // output register: load on grant, empty on a drain without reload, hold otherwise
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= EMPTY;
            Out_Data <= '0;
            Out_Chan <= '0;
        end else if (|grant) begin
            state    <= FULL;
            Out_Data <= In_Data[grant_idx*WIDTH +: WIDTH];
            Out_Chan <= grant_idx;
        end else if (Out_Ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mu0_arb_mux.sv
// tb_mu0_arb_mux: directed and randomized checks of both arbitration modes against a behavioural model
module tb_mu0_arb_mux;
    import mu0_mux_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [47:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  rdy_rr, rdy_fx;
    logic [11:0] dat_rr, dat_fx;
    logic [1:0]  ch_rr, ch_fx;
    logic        v_rr, v_fx;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = round-robin DUT, index 1 = fixed-priority DUT
    int m_valid [2];
    int m_data  [2];
    int m_chan  [2];
    int m_ptr;

    always #5 clk = ~clk;

    mu0_arb_mux #(.WIDTH(12), .N(4), .MODE(MODE_RR)) dut (
        .Clk(clk), .nReset(nreset), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(rdy_rr),
        .Out_Data(dat_rr), .Out_Chan(ch_rr), .Out_Valid(v_rr), .Out_Ready(out_ready)
    );

    mu0_arb_mux #(.WIDTH(12), .N(4), .MODE(MODE_FIXED)) dut_fx (
        .Clk(clk), .nReset(nreset), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(rdy_fx),
        .Out_Data(dat_fx), .Out_Chan(ch_fx), .Out_Valid(v_fx), .Out_Ready(out_ready)
    );

    // which channel the arbiter should pick this cycle, -1 if none
    function automatic int pick(int k);
        int c;
        if (!nreset) return -1;
        if (m_valid[k] != 0 && !out_ready) return -1;
        for (int i = 0; i < 4; i++) begin
            c = ((k == 0 ? m_ptr : 0) + i) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int k);
        int g;
        g = pick(k);
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_data[k]  = 0;
            m_chan[k]  = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_clock();
        int g;
        for (int k = 0; k < 2; k++) begin
            g = pick(k);
            if (g >= 0) begin
                m_valid[k] = 1;
                m_data[k]  = int'(in_data[g*12 +: 12]);
                m_chan[k]  = g;
                if (k == 0) m_ptr = (g + 1) % 4;
            end else if (out_ready) begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        in_data = 48'({$urandom, $urandom});
        in_valid = 4'hF;
        out_ready = 1'($urandom);
        #2;
        checks++; if ({v_rr, dat_rr, ch_rr} !== 15'd0) begin errors++; $display("FAIL reset_out_rr got %h exp 0", {v_rr, dat_rr, ch_rr}); end
        checks++; if ({v_fx, dat_fx, ch_fx} !== 15'd0) begin errors++; $display("FAIL reset_out_fx got %h exp 0", {v_fx, dat_fx, ch_fx}); end
        checks++; if (rdy_rr !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", rdy_rr); end
        @(posedge clk);
        #1;
        in_valid = 4'b0001;
        nreset = 1'b1;
        out_ready = 1'b0;
        tick();
        checks++; if (v_rr !== 1'b1) begin errors++; $display("FAIL reset_preload got %b exp 1", v_rr); end
        #2;
        nreset = 1'b0;
        #1;
        checks++; if ({v_rr, dat_rr, ch_rr} !== 15'd0) begin errors++; $display("FAIL reset_midcycle got %h exp 0", {v_rr, dat_rr, ch_rr}); end
        checks++; if (rdy_rr !== 4'b0000 || rdy_fx !== 4'b0000) begin errors++; $display("FAIL reset_midcycle_ready got %b/%b exp 0000", rdy_rr, rdy_fx); end
        model_reset();
        in_valid = 4'b0000;
        #2;
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid = 4'b0100;
        in_data[24 +: 12] = 12'hABC;
        out_ready = 1'b1;
        #1;
        checks++; if (rdy_rr !== 4'b0100 || rdy_fx !== 4'b0100) begin errors++; $display("FAIL single_ready got %b/%b exp 0100", rdy_rr, rdy_fx); end
        tick();
        checks++; if ({v_rr, dat_rr, ch_rr} !== {1'b1, 12'hABC, 2'd2}) begin errors++; $display("FAIL single_out got %b %h %0d exp 1 abc 2", v_rr, dat_rr, ch_rr); end
    endtask

    task automatic test_rr_fairness();
        nreset = 1'b0;
        model_reset();
        #1;
        nreset = 1'b1;
        in_valid = 4'hF;
        in_data = {12'h103, 12'h102, 12'h101, 12'h100};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (rdy_rr !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", c, rdy_rr, 4'(1 << (c % 4))); end
            tick();
            checks++; if ({v_rr, dat_rr, ch_rr} !== {1'b1, 12'h100 + 12'(c % 4), 2'(c % 4)}) begin errors++; $display("FAIL rr_out[%0d] got %b %h %0d exp 1 %h %0d", c, v_rr, dat_rr, ch_rr, 12'h100 + 12'(c % 4), c % 4); end
        end
    endtask

    task automatic test_fixed();
        in_valid = 4'b1110;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy_fx !== 4'b0010) begin errors++; $display("FAIL fixed_ready[%0d] got %b exp 0010", c, rdy_fx); end
            tick();
            checks++; if ({v_fx, ch_fx, dat_fx} !== {1'b1, 2'd1, 12'h101}) begin errors++; $display("FAIL fixed_out[%0d] got %b %0d %h exp 1 1 101", c, v_fx, ch_fx, dat_fx); end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] d1;
        d1 = 12'($urandom);
        in_valid = 4'b0001;
        in_data[0 +: 12] = 12'h555;
        out_ready = 1'b1;
        #1;
        tick();
        checks++; if ({v_rr, dat_rr} !== {1'b1, 12'h555}) begin errors++; $display("FAIL bp_load got %b %h exp 1 555", v_rr, dat_rr); end
        in_valid = 4'b0010;
        in_data[12 +: 12] = d1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy_rr !== 4'b0000 || rdy_fx !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b/%b exp 0000", c, rdy_rr, rdy_fx); end
            tick();
            checks++; if ({v_rr, dat_rr, ch_rr} !== {1'b1, 12'h555, 2'd0}) begin errors++; $display("FAIL bp_hold[%0d] got %b %h %0d exp 1 555 0", c, v_rr, dat_rr, ch_rr); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (rdy_rr !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", rdy_rr); end
        tick();
        checks++; if ({v_rr, dat_rr, ch_rr} !== {1'b1, d1, 2'd1}) begin errors++; $display("FAIL bp_reload got %b %h %0d exp 1 %h 1", v_rr, dat_rr, ch_rr, d1); end
    endtask

    task automatic test_drain();
        logic [11:0] held;
        held = in_data[12 +: 12];
        in_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        tick();
        checks++; if ({v_rr, dat_rr} !== {1'b0, held}) begin errors++; $display("FAIL drain_out got %b %h exp 0 %h", v_rr, dat_rr, held); end
        #1;
        tick();
        in_valid = 4'hF;
        #1;
        checks++; if (rdy_rr !== 4'b0100) begin errors++; $display("FAIL drain_ptr_kept got %b exp 0100", rdy_rr); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_data = 48'({$urandom, $urandom});
            in_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (rdy_rr !== exp_rdy(0)) begin errors++; $display("FAIL rand_ready_rr[%0d] got %b exp %b", c, rdy_rr, exp_rdy(0)); end
            checks++; if (rdy_fx !== exp_rdy(1)) begin errors++; $display("FAIL rand_ready_fx[%0d] got %b exp %b", c, rdy_fx, exp_rdy(1)); end
            tick();
            checks++; if ({v_rr, dat_rr, ch_rr} !== {1'(m_valid[0]), 12'(m_data[0]), 2'(m_chan[0])}) begin errors++; $display("FAIL rand_out_rr[%0d] got %b %h %0d exp %0d %h %0d", c, v_rr, dat_rr, ch_rr, m_valid[0], m_data[0], m_chan[0]); end
            checks++; if ({v_fx, dat_fx, ch_fx} !== {1'(m_valid[1]), 12'(m_data[1]), 2'(m_chan[1])}) begin errors++; $display("FAIL rand_out_fx[%0d] got %b %h %0d exp %0d %h %0d", c, v_fx, dat_fx, ch_fx, m_valid[1], m_data[1], m_chan[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed();
        test_backpressure();
        test_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
